// File: rtl/carfield_pkg.sv
// Shared Carfield definitions: AXI response codes, responder FSM states,
// the default DECERR read payload and the saturating fault-count helper.
package carfield_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    localparam logic [63:0] DefaultRespData = 64'hBADC_AB1E_DEAD_BEEF;
    localparam int unsigned FaultCntWidth   = 16;

    // Adds 0..2 events to the fault count, sticking at all-ones.
    function automatic logic [FaultCntWidth-1:0] fault_cnt_add(
        input logic [FaultCntWidth-1:0] cnt,
        input logic [1:0]               inc
    );
        logic [FaultCntWidth:0] sum;
        sum = {1'b0, cnt} + {{(FaultCntWidth - 1){1'b0}}, inc};
        return sum[FaultCntWidth] ? {FaultCntWidth{1'b1}} : sum[FaultCntWidth-1:0];
    endfunction

endpackage

// File: rtl/carfield_decerr_fault_log.sv
// First-fault record, saturating fault counter and fault interrupt, shared by
// the Carfield error slaves. A clear coinciding with a new fault keeps the fault.
module carfield_decerr_fault_log
    import carfield_pkg::*;
#(
    parameter int unsigned AddrWidth = 48
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     aw_hs_i,
    input  logic [AddrWidth-1:0]     aw_addr_i,
    input  logic                     ar_hs_i,
    input  logic [AddrWidth-1:0]     ar_addr_i,
    output logic                     fault_valid_o,
    output logic [AddrWidth-1:0]     fault_addr_o,
    output logic                     fault_write_o,
    output logic [FaultCntWidth-1:0] fault_cnt_o,
    output logic                     irq_o
);

    logic [1:0] inc;
    logic       capture;

    assign inc     = {1'b0, aw_hs_i} + {1'b0, ar_hs_i};
    assign capture = (aw_hs_i || ar_hs_i) && (!fault_valid_o || clear_i);

    // The write address takes priority when both channels fault together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_valid_o <= 1'b0;
            fault_addr_o  <= '0;
            fault_write_o <= 1'b0;
            fault_cnt_o   <= '0;
            irq_o         <= 1'b0;
        end else begin
            irq_o       <= capture;
            fault_cnt_o <= fault_cnt_add(clear_i ? '0 : fault_cnt_o, inc);
            if (capture) begin
                fault_valid_o <= 1'b1;
                fault_addr_o  <= aw_hs_i ? aw_addr_i : ar_addr_i;
                fault_write_o <= aw_hs_i;
            end else if (clear_i) begin
                fault_valid_o <= 1'b0;
                fault_addr_o  <= '0;
                fault_write_o <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/carfield_decerr_responder.sv
// AXI4 terminating slave for unmapped Carfield windows: accepts everything,
// drains writes, answers DECERR and logs the first fault.
module carfield_decerr_responder
    import carfield_pkg::*;
#(
    parameter int unsigned AddrWidth = 48,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 6,
    parameter logic [63:0] RespData  = DefaultRespData
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     aw_valid_i,
    output logic                     aw_ready_o,
    input  logic [IdWidth-1:0]       aw_id_i,
    input  logic [AddrWidth-1:0]     aw_addr_i,
    input  logic                     w_valid_i,
    output logic                     w_ready_o,
    input  logic                     w_last_i,
    output logic                     b_valid_o,
    input  logic                     b_ready_i,
    output logic [IdWidth-1:0]       b_id_o,
    output logic [1:0]               b_resp_o,
    input  logic                     ar_valid_i,
    output logic                     ar_ready_o,
    input  logic [IdWidth-1:0]       ar_id_i,
    input  logic [AddrWidth-1:0]     ar_addr_i,
    input  logic [7:0]               ar_len_i,
    output logic                     r_valid_o,
    input  logic                     r_ready_i,
    output logic [IdWidth-1:0]       r_id_o,
    output logic [DataWidth-1:0]     r_data_o,
    output logic [1:0]               r_resp_o,
    output logic                     r_last_o,
    input  logic                     clear_i,
    output logic                     fault_valid_o,
    output logic [AddrWidth-1:0]     fault_addr_o,
    output logic                     fault_write_o,
    output logic [FaultCntWidth-1:0] fault_cnt_o,
    output logic                     irq_o
);

    w_state_e           w_state_q, w_state_d;
    r_state_e           r_state_q, r_state_d;
    logic [IdWidth-1:0] w_id_q;
    logic [IdWidth-1:0] r_id_q;
    logic [7:0]         r_cnt_q, r_cnt_d;
    logic               init_done_q;
    logic               aw_hs;
    logic               ar_hs;

    assign aw_hs = aw_valid_i && aw_ready_o;
    assign ar_hs = ar_valid_i && ar_ready_o;

    // init_done_q keeps both address readies low for the first cycle out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            init_done_q <= 1'b0;
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            w_id_q      <= '0;
            r_id_q      <= '0;
            r_cnt_q     <= '0;
        end else begin
            init_done_q <= 1'b1;
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            r_cnt_q     <= r_cnt_d;
            if (aw_hs) begin
                w_id_q <= aw_id_i;
            end
            if (ar_hs) begin
                r_id_q <= ar_id_i;
            end
        end
    end

    always_comb begin
        w_state_d  = w_state_q;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        b_resp_o   = RESP_OKAY;
        unique case (w_state_q)
            W_IDLE: begin
                aw_ready_o = init_done_q;
                if (aw_valid_i && init_done_q) begin
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                w_ready_o = 1'b1;
                if (w_valid_i && w_last_i) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                b_valid_o = 1'b1;
                b_resp_o  = RESP_DECERR;
                if (b_ready_i) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign b_id_o = w_id_q;

    // r_cnt_q counts remaining beats after the current one; zero marks the last.
    always_comb begin
        r_state_d  = r_state_q;
        r_cnt_d    = r_cnt_q;
        ar_ready_o = 1'b0;
        r_valid_o  = 1'b0;
        r_resp_o   = RESP_OKAY;
        r_last_o   = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                ar_ready_o = init_done_q;
                if (ar_valid_i && init_done_q) begin
                    r_cnt_d   = ar_len_i;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                r_valid_o = 1'b1;
                r_resp_o  = RESP_DECERR;
                r_last_o  = (r_cnt_q == 8'd0);
                if (r_ready_i) begin
                    if (r_cnt_q == 8'd0) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d = r_cnt_q - 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign r_id_o   = r_id_q;
    assign r_data_o = RespData[DataWidth-1:0];

    carfield_decerr_fault_log #(
        .AddrWidth (AddrWidth)
    ) u_fault_log (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (clear_i),
        .aw_hs_i       (aw_hs),
        .aw_addr_i     (aw_addr_i),
        .ar_hs_i       (ar_hs),
        .ar_addr_i     (ar_addr_i),
        .fault_valid_o (fault_valid_o),
        .fault_addr_o  (fault_addr_o),
        .fault_write_o (fault_write_o),
        .fault_cnt_o   (fault_cnt_o),
        .irq_o         (irq_o)
    );

endmodule

// File: tb/tb_carfield_decerr_responder.sv
// Bench for carfield_decerr_responder: transaction-level model checked every
// cycle, directed scenarios with literal expectations, and a fault-log saturation run.
module tb_carfield_decerr_responder;
    import carfield_pkg::*;

    localparam int AW = 48;
    localparam int DW = 64;
    localparam int IW = 6;
    localparam logic [63:0] RD = 64'hBADC_AB1E_DEAD_BEEF;

    logic          clk_i;
    logic          rst_i;
    logic          aw_valid_i, aw_ready_o;
    logic [IW-1:0] aw_id_i;
    logic [AW-1:0] aw_addr_i;
    logic          w_valid_i, w_ready_o, w_last_i;
    logic          b_valid_o, b_ready_i;
    logic [IW-1:0] b_id_o;
    logic [1:0]    b_resp_o;
    logic          ar_valid_i, ar_ready_o;
    logic [IW-1:0] ar_id_i;
    logic [AW-1:0] ar_addr_i;
    logic [7:0]    ar_len_i;
    logic          r_valid_o, r_ready_i;
    logic [IW-1:0] r_id_o;
    logic [DW-1:0] r_data_o;
    logic [1:0]    r_resp_o;
    logic          r_last_o;
    logic          clear_i;
    logic          fault_valid_o;
    logic [AW-1:0] fault_addr_o;
    logic          fault_write_o;
    logic [15:0]   fault_cnt_o;
    logic          irq_o;

    logic          log_rst, log_clear, log_aw_hs, log_ar_hs;
    logic [AW-1:0] log_aw_addr, log_ar_addr;
    logic          log_valid, log_write, log_irq;
    logic [AW-1:0] log_addr;
    logic [15:0]   log_cnt;

    int testsRun = 0;
    int testsFailed = 0;
    int wBeats = 0;
    int irqPulses = 0;
    int logIrqPulses = 0;

    carfield_decerr_responder #(
        .AddrWidth (AW),
        .DataWidth (DW),
        .IdWidth   (IW),
        .RespData  (RD)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .aw_valid_i    (aw_valid_i),
        .aw_ready_o    (aw_ready_o),
        .aw_id_i       (aw_id_i),
        .aw_addr_i     (aw_addr_i),
        .w_valid_i     (w_valid_i),
        .w_ready_o     (w_ready_o),
        .w_last_i      (w_last_i),
        .b_valid_o     (b_valid_o),
        .b_ready_i     (b_ready_i),
        .b_id_o        (b_id_o),
        .b_resp_o      (b_resp_o),
        .ar_valid_i    (ar_valid_i),
        .ar_ready_o    (ar_ready_o),
        .ar_id_i       (ar_id_i),
        .ar_addr_i     (ar_addr_i),
        .ar_len_i      (ar_len_i),
        .r_valid_o     (r_valid_o),
        .r_ready_i     (r_ready_i),
        .r_id_o        (r_id_o),
        .r_data_o      (r_data_o),
        .r_resp_o      (r_resp_o),
        .r_last_o      (r_last_o),
        .clear_i       (clear_i),
        .fault_valid_o (fault_valid_o),
        .fault_addr_o  (fault_addr_o),
        .fault_write_o (fault_write_o),
        .fault_cnt_o   (fault_cnt_o),
        .irq_o         (irq_o)
    );

    // Second fault log driven directly, so saturation needs only ~33k cycles.
    carfield_decerr_fault_log #(
        .AddrWidth (AW)
    ) u_log (
        .clk_i         (clk_i),
        .rst_i         (log_rst),
        .clear_i       (log_clear),
        .aw_hs_i       (log_aw_hs),
        .aw_addr_i     (log_aw_addr),
        .ar_hs_i       (log_ar_hs),
        .ar_addr_i     (log_ar_addr),
        .fault_valid_o (log_valid),
        .fault_addr_o  (log_addr),
        .fault_write_o (log_write),
        .fault_cnt_o   (log_cnt),
        .irq_o         (log_irq)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Transaction-level model: what is owed on each channel, plus the fault record.
    bit          modelStarted = 0;
    bit          mReadyEn;
    bit          mWOpen;
    bit          mBOwed;
    int          mAwId;
    int          mRLeft;
    int          mArId;
    bit          mFv;
    bit          mFw;
    bit          mIrq;
    logic [AW-1:0] mFa;
    int          mCnt;

    function automatic bit eAwReady();
        return mReadyEn && !mWOpen && !mBOwed;
    endfunction

    function automatic bit eArReady();
        return mReadyEn && (mRLeft == 0);
    endfunction

    always @(posedge clk_i) begin
        bit awHs, wHs, bHs, arHs, rHs, newFault;
        int n;
        if (rst_i) begin
            mReadyEn = 0; mWOpen = 0; mBOwed = 0; mAwId = 0;
            mRLeft = 0; mArId = 0;
            mFv = 0; mFw = 0; mFa = '0; mCnt = 0; mIrq = 0;
        end else begin
            awHs = aw_valid_i && eAwReady();
            wHs  = w_valid_i && mWOpen;
            bHs  = b_ready_i && mBOwed;
            arHs = ar_valid_i && eArReady();
            rHs  = r_ready_i && (mRLeft > 0);
            if (awHs) begin
                mWOpen = 1;
                mAwId  = int'(aw_id_i);
            end else if (wHs && w_last_i) begin
                mWOpen = 0;
                mBOwed = 1;
            end else if (bHs) begin
                mBOwed = 0;
            end
            if (arHs) begin
                mRLeft = int'(ar_len_i) + 1;
                mArId  = int'(ar_id_i);
            end else if (rHs) begin
                mRLeft = mRLeft - 1;
            end
            n = int'(awHs) + int'(arHs);
            newFault = (n > 0) && (!mFv || clear_i);
            if (clear_i) begin
                mCnt = 0; mFv = 0; mFa = '0; mFw = 0;
            end
            if (newFault) begin
                mFv = 1;
                mFa = awHs ? aw_addr_i : ar_addr_i;
                mFw = awHs;
            end
            mCnt = (mCnt + n > 65535) ? 65535 : mCnt + n;
            mIrq = newFault;
            mReadyEn = 1;
        end
        modelStarted = 1;
    end

    always @(negedge clk_i) begin
        if (modelStarted) begin
            checkOutput("aw_ready", aw_ready_o, eAwReady());
            checkOutput("w_ready", w_ready_o, mWOpen);
            checkOutput("b_valid", b_valid_o, mBOwed);
            if (mBOwed) begin
                checkOutput("b_id", b_id_o, mAwId);
                checkOutput("b_resp", b_resp_o, 2'b11);
            end
            checkOutput("ar_ready", ar_ready_o, eArReady());
            checkOutput("r_valid", r_valid_o, mRLeft > 0);
            if (mRLeft > 0) begin
                checkOutput("r_id", r_id_o, mArId);
                checkOutput("r_data", r_data_o, RD);
                checkOutput("r_resp", r_resp_o, 2'b11);
                checkOutput("r_last", r_last_o, mRLeft == 1);
            end
            checkOutput("fault_valid", fault_valid_o, mFv);
            checkOutput("fault_addr", fault_addr_o, mFa);
            checkOutput("fault_write", fault_write_o, mFw);
            checkOutput("fault_cnt", fault_cnt_o, mCnt);
            checkOutput("irq", irq_o, mIrq);
        end
        if (w_valid_i && w_ready_o) wBeats++;
        if (irq_o) irqPulses++;
        if (log_irq) logIrqPulses++;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic awSend(input int id, input logic [AW-1:0] addr);
        bit hs = 0;
        aw_valid_i = 1; aw_id_i = IW'(id); aw_addr_i = addr;
        for (int c = 0; c < 50 && !hs; c++) begin
            @(negedge clk_i);
            hs = aw_ready_o;
            tick();
        end
        aw_valid_i = 0;
        if (!hs) checkOutput("aw_timeout", 1, 0);
    endtask

    task automatic arSend(input int id, input logic [AW-1:0] addr, input int len);
        bit hs = 0;
        ar_valid_i = 1; ar_id_i = IW'(id); ar_addr_i = addr; ar_len_i = 8'(len);
        for (int c = 0; c < 50 && !hs; c++) begin
            @(negedge clk_i);
            hs = ar_ready_o;
            tick();
        end
        ar_valid_i = 0;
        if (!hs) checkOutput("ar_timeout", 1, 0);
    endtask

    task automatic wSend(input int beats);
        for (int i = 0; i < beats; i++) begin
            bit hs = 0;
            w_valid_i = 1; w_last_i = (i == beats - 1);
            for (int c = 0; c < 50 && !hs; c++) begin
                @(negedge clk_i);
                hs = w_ready_o;
                tick();
            end
            if (!hs) checkOutput("w_timeout", 1, 0);
        end
        w_valid_i = 0; w_last_i = 0;
    endtask

    task automatic bTake(input int id);
        bit hs = 0;
        b_ready_i = 1;
        for (int c = 0; c < 50 && !hs; c++) begin
            @(negedge clk_i);
            if (b_valid_o) begin
                hs = 1;
                checkOutput("b_id_literal", b_id_o, id);
                checkOutput("b_resp_literal", b_resp_o, 2'b11);
            end
            tick();
        end
        b_ready_i = 0;
        if (!hs) checkOutput("b_timeout", 1, 0);
    endtask

    task automatic rTake(input int total, input int stopAfter, input bit toggle, input int id);
        int beats = 0;
        int lasts = 0;
        for (int c = 0; c < 200 && beats < stopAfter; c++) begin
            r_ready_i = toggle ? (c % 2 == 0) : 1'b1;
            @(negedge clk_i);
            if (r_valid_o && r_ready_i) begin
                beats++;
                if (r_last_o) lasts++;
                if (beats == total) begin
                    checkOutput("r_last_final", r_last_o, 1);
                    checkOutput("r_id_literal", r_id_o, id);
                    checkOutput("r_data_literal", r_data_o, RD);
                end
            end
            tick();
        end
        r_ready_i = 0;
        checkOutput("r_beat_count", beats, stopAfter);
        checkOutput("r_last_count", lasts, (stopAfter == total) ? 1 : 0);
    endtask

    task automatic applyStimulus(input int testId);
        int irqBefore;
        case (testId)
            1: begin
                // W presented before AW must not be accepted; then a 3-beat write.
                w_valid_i = 1; tick(); tick(); w_valid_i = 0;
                wBeats = 0; irqBefore = irqPulses;
                awSend(5, 48'h5000_0000);
                checkOutput("t1_fault_addr", fault_addr_o, 48'h5000_0000);
                checkOutput("t1_fault_write", fault_write_o, 1);
                checkOutput("t1_fault_cnt", fault_cnt_o, 1);
                checkOutput("t1_irq_now", irq_o, 1);
                wSend(3);
                bTake(5);
                checkOutput("t1_w_beats", wBeats, 3);
                checkOutput("t1_irq_pulses", irqPulses - irqBefore, 1);
            end
            2: begin
                arSend(2, 48'h5000_0100, 7);
                checkOutput("t2_fault_cnt", fault_cnt_o, 2);
                checkOutput("t2_record_kept", fault_addr_o, 48'h5000_0000);
                rTake(8, 8, 1, 2);
            end
            3: begin
                clear_i = 1; tick(); clear_i = 0;
                checkOutput("t3_cleared_valid", fault_valid_o, 0);
                checkOutput("t3_cleared_cnt", fault_cnt_o, 0);
                fork
                    begin awSend(9, 48'h5100_0000); wSend(2); bTake(9); end
                    begin arSend(3, 48'h5000_0010, 3); rTake(4, 4, 0, 3); end
                join
                checkOutput("t3_fault_addr", fault_addr_o, 48'h5100_0000);
                checkOutput("t3_fault_write", fault_write_o, 1);
                checkOutput("t3_fault_cnt", fault_cnt_o, 2);
            end
            4: begin
                irqBefore = irqPulses;
                @(negedge clk_i);
                checkOutput("t4_ar_ready_pre", ar_ready_o, 1);
                ar_valid_i = 1; ar_id_i = 6'd1; ar_addr_i = 48'h2000_1000; ar_len_i = 8'd0;
                clear_i = 1;
                tick();
                ar_valid_i = 0; clear_i = 0;
                checkOutput("t4_fault_addr", fault_addr_o, 48'h2000_1000);
                checkOutput("t4_fault_write", fault_write_o, 0);
                checkOutput("t4_fault_cnt", fault_cnt_o, 1);
                checkOutput("t4_irq_now", irq_o, 1);
                rTake(1, 1, 0, 1);
                checkOutput("t4_irq_pulses", irqPulses - irqBefore, 1);
            end
            5: begin
                arSend(7, 48'h3000_0000, 15);
                rTake(16, 5, 0, 7);
                rst_i = 1;
                tick();
                checkOutput("t5_r_valid", r_valid_o, 0);
                checkOutput("t5_ar_ready", ar_ready_o, 0);
                checkOutput("t5_aw_ready", aw_ready_o, 0);
                checkOutput("t5_r_id", r_id_o, 0);
                checkOutput("t5_r_last", r_last_o, 0);
                checkOutput("t5_fault_valid", fault_valid_o, 0);
                checkOutput("t5_fault_cnt", fault_cnt_o, 0);
                rst_i = 0;
                arSend(4, 48'h3000_0040, 0);
                rTake(1, 1, 0, 4);
            end
            6: begin
                // Fault-log saturation: 2 faults per cycle, then a single one to hit 0xFFFF.
                log_rst = 0; tick();
                log_aw_hs = 1; log_ar_hs = 1;
                log_aw_addr = 48'h0000_7000_0000; log_ar_addr = 48'h0000_7100_0000;
                repeat (32767) tick();
                log_aw_hs = 0; log_ar_hs = 0; tick();
                checkOutput("t6_cnt_65534", log_cnt, 16'd65534);
                checkOutput("t6_addr", log_addr, 48'h0000_7000_0000);
                checkOutput("t6_write", log_write, 1);
                log_ar_hs = 1; tick(); log_ar_hs = 0;
                checkOutput("t6_cnt_max", log_cnt, 16'hFFFF);
                log_aw_hs = 1; log_ar_hs = 1;
                repeat (2500) tick();
                log_aw_hs = 0; log_ar_hs = 0; tick();
                checkOutput("t6_cnt_sat", log_cnt, 16'hFFFF);
                checkOutput("t6_irq_pulses", logIrqPulses, 1);
                log_clear = 1; tick(); log_clear = 0;
                checkOutput("t6_clear_cnt", log_cnt, 0);
                checkOutput("t6_clear_valid", log_valid, 0);
            end
            default: ;
        endcase
    endtask

    initial begin
        rst_i = 1; clear_i = 0;
        aw_valid_i = 0; aw_id_i = '0; aw_addr_i = '0;
        w_valid_i = 0; w_last_i = 0; b_ready_i = 0;
        ar_valid_i = 0; ar_id_i = '0; ar_addr_i = '0; ar_len_i = '0;
        r_ready_i = 0;
        log_rst = 1; log_clear = 0; log_aw_hs = 0; log_ar_hs = 0;
        log_aw_addr = '0; log_ar_addr = '0;
        repeat (3) tick();
        checkOutput("rst_aw_ready", aw_ready_o, 0);
        checkOutput("rst_ar_ready", ar_ready_o, 0);
        checkOutput("rst_b_valid", b_valid_o, 0);
        checkOutput("rst_r_valid", r_valid_o, 0);
        checkOutput("rst_b_id", b_id_o, 0);
        checkOutput("rst_b_resp", b_resp_o, 0);
        checkOutput("rst_r_resp", r_resp_o, 0);
        checkOutput("rst_fault_cnt", fault_cnt_o, 0);
        checkOutput("rst_irq", irq_o, 0);
        checkOutput("rst_r_data", r_data_o, RD);
        rst_i = 0;
        checkOutput("post_rst_aw_ready", aw_ready_o, 0);
        for (int t = 1; t <= 6; t++) begin
            applyStimulus(t);
            repeat (3) tick();
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
